cdc_handshake_tx: RTL
=====================

# cdc_handshake_tx

Source-domain launcher for multi-bit clock-domain crossings. Accepts one word at a time on a valid/ready interface, drives it onto a held-stable bus, then raises a level enable that the destination-domain data synchronizer samples. A full 4-phase req/ack handshake guarantees that each word is captured exactly once before the bus may change. The block sits in the transmitting clock domain, opposite the destination-side data synchronizer that consumes `async_bus` / `async_bus_en`.

## Interface
- `STAGES_NUM`, 2: flops in the ack synchronizer chain (≥2).
- `BUS_WIDTH`, 8: data word width.
- `SETUP_CYCLES`, 1: cycles the bus is held stable before `async_bus_en` rises (≥1).

- `CLK`  in  1  source-domain clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `tx_data`  in  BUS_WIDTH  word to transfer.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a word this cycle.
- `async_bus`  out  BUS_WIDTH  registered crossing bus.
- `async_bus_en`  out  1  registered request level to the destination domain.
- `ack_async`  in  1  acknowledge level from the destination domain (asynchronous to CLK).
- `busy`  out  1  transfer in progress.
- `done_pulse`  out  1  one-cycle pulse when a handshake completes.

## Operation
- Ack path: `ack_async` feeds a STAGES_NUM-flop shift chain, reset 0. `ack_sync` is the last stage. No other logic touches `ack_async`.
- FSM states: IDLE, SETUP, REQ_HI, REQ_LO. Reset state is IDLE.
- Outputs decoded from registered state only: `tx_ready = (state==IDLE) && !ack_sync`; `busy = (state!=IDLE)`.
- IDLE:
  - On `tx_valid && tx_ready`: `bus_reg <= tx_data`, `cnt <= SETUP_CYCLES-1`, go to SETUP.
  - `tx_valid` while `tx_ready`=0 is ignored. Nothing is captured, and the sender holds its data.
- SETUP:
  - If `cnt==0`: `req_reg <= 1`, go to REQ_HI.
  - Else `cnt <= cnt-1`.
- REQ_HI: wait for `ack_sync==1`, then `req_reg <= 0` and go to REQ_LO. There is no timeout; the block waits indefinitely.
- REQ_LO: wait for `ack_sync==0`, then `done_reg <= 1` for one cycle and go to IDLE.
- Bus rules:
  - `async_bus = bus_reg`, `async_bus_en = req_reg`, both driven directly from flops.
  - `bus_reg` changes only on acceptance in IDLE. It is therefore stable from SETUP entry until the next acceptance, which can occur only after `ack_sync` has returned low.
- Boundary conditions:
  - Ack high while in IDLE (stale or spurious): `tx_ready` is held low until `ack_sync` falls.
  - Ack low while in SETUP: no effect.
  - Ack pulse shorter than the sync chain: may be missed. The destination must hold ack as a level until req falls.
  - Reset mid-transfer: all flops clear asynchronously, so `async_bus_en` drops immediately and `async_bus` becomes 0. After release, the first acceptance waits for `ack_sync==0`.

## Timing
- Reset values: `tx_ready`=1, `async_bus`=0, `async_bus_en`=0, `busy`=0, `done_pulse`=0.
- Word accepted at edge E:
  - `async_bus` is valid from E.
  - `async_bus_en` rises at edge E+SETUP_CYCLES.
  - `busy` rises at E.
- `ack_async` rising sampled at edge A: `ack_sync` is high after edge A+STAGES_NUM-1. `async_bus_en` falls at edge A+STAGES_NUM.
- `ack_async` falling sampled at edge F: `done_pulse` rises at edge F+STAGES_NUM and lasts one cycle. `busy` falls at the same edge and `tx_ready` rises at the same edge, so back-to-back acceptance is possible at edge F+STAGES_NUM+1.
- Minimum source-domain cycles per word: SETUP_CYCLES + 2·STAGES_NUM + 2, plus the destination response time.

## Test plan
- Single transfer, defaults:
  - Stimulus: `tx_data`=0xA5 accepted at edge 0; the bench model raises ack 3 cycles after seeing en, then drops ack 3 cycles after en falls.
  - Required: `async_bus`=0xA5 from edge 0, en high at edge 1, exactly one `done_pulse`, and `async_bus` still 0xA5 afterwards.
- Back-to-back:
  - Stimulus: `tx_valid` held high with 0x01, 0x02, 0x03.
  - Required: each word is accepted only while `tx_ready`=1, three `done_pulse`s in order, and the bus never changes while en=1 or ack_sync=1.
- Setup delay:
  - Stimulus: SETUP_CYCLES=3, word 0x3C.
  - Required: en rises exactly 3 edges after acceptance, and the bus is stable throughout.
- Stale ack:
  - Stimulus: hold `ack_async`=1 from reset, then assert `tx_valid` with 0x77.
  - Required: `tx_ready`=0 and no capture. Release ack, then `tx_ready`=1 two edges later and 0x77 is accepted.
- Reset mid-transfer:
  - Stimulus: assert RST in REQ_HI with bus 0xFF.
  - Required: en and bus go to 0 immediately, `busy`=0, and no `done_pulse`. The next transfer completes normally.
- Slow ack:
  - Stimulus: ack is withheld for 100 cycles.
  - Required: the block stays in REQ_HI with en=1, `tx_ready`=0 and the bus stable. It completes once ack arrives.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source-side 4-phase req/ack launcher driving a held-stable multi-bit crossing bus
module cdc_handshake_tx #(
  parameter int STAGES_NUM   = 2,
  parameter int BUS_WIDTH    = 8,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [BUS_WIDTH-1:0] async_bus,
  output logic                 async_bus_en,
  input  logic                 ack_async,
  output logic                 busy,
  output logic                 done_pulse
);
  localparam int CW = SETUP_CYCLES > 1 ? $clog2(SETUP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;
  state_t                state;
  logic [STAGES_NUM-1:0] ack_ff;
  logic                  ack_sync;
  logic [CW-1:0]         cnt;
  logic [BUS_WIDTH-1:0]  bus_reg;
  logic                  req_reg;
  logic                  done_reg;
  assign ack_sync     = ack_ff[STAGES_NUM-1];
  assign tx_ready     = (state == IDLE) && !ack_sync;
  assign busy         = (state != IDLE);
  assign async_bus    = bus_reg;
  assign async_bus_en = req_reg;
  assign done_pulse   = done_reg;
  // ack_async is only ever touched by this chain
  always_ff @(posedge CLK or negedge RST)
    if (!RST) ack_ff <= '0;
    else      ack_ff <= {ack_ff[STAGES_NUM-2:0], ack_async};
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      bus_reg  <= '0;
      req_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE:
          if (tx_valid && tx_ready) begin
            bus_reg <= tx_data;
            cnt     <= CW'(SETUP_CYCLES - 1);
            state   <= SETUP;
          end
        SETUP:
          if (cnt == '0) begin
            req_reg <= 1'b1;
            state   <= REQ_HI;
          end else cnt <= cnt - CW'(1);
        REQ_HI:
          if (ack_sync) begin
            req_reg <= 1'b0;
            state   <= REQ_LO;
          end
        REQ_LO:
          if (!ack_sync) begin
            done_reg <= 1'b1;
            state    <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
